// File: rtl/fsm_req_shaper.sv
// Request conditioner ahead of the 4-agent arbiter: queues job pulses per agent,
// holds each granted request for a fixed burst and forces a gap between bursts.

module fsm_req_shaper_chan #(
   parameter int BURST_LEN = 4,
   parameter int GAP_LEN   = 2,
   parameter int CNT_W     = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             job_i,
   input  logic             gnt_i,
   output logic             req_o,
   output logic             done_o,
   output logic             gnt_err_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] pend_o
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   localparam logic [BW-1:0] BLAST = BW'(BURST_LEN - 1);
   localparam logic [GW-1:0] GLAST = GW'(GAP_LEN - 1);
   localparam logic [CNT_W-1:0] PMAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, REQ, BURST, GAP} state_t;

   state_t           state_q;
   logic [BW-1:0]    bcnt_q;
   logic [GW-1:0]    gcnt_q;
   logic [CNT_W-1:0] pend_q;
   logic             done_q;
   logic             gerr_q;
   logic             ovf_q;
   logic             last_beat;
   logic             sat;

   assign last_beat = (state_q == BURST) && gnt_i && (bcnt_q == BLAST);
   assign sat       = (pend_q == PMAX);

   // Job and completion on one edge cancel, even when saturated.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bcnt_q  <= '0;
         gcnt_q  <= '0;
         pend_q  <= '0;
         done_q  <= 1'b0;
         gerr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         gerr_q <= 1'b0;
         if (job_i && !last_beat) begin
            if (sat)
               ovf_q <= 1'b1;
            else
               pend_q <= pend_q + 1'b1;
         end else if (!job_i && last_beat) begin
            pend_q <= pend_q - 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (gnt_i)
                  gerr_q <= 1'b1;
               if (pend_q != '0)
                  state_q <= REQ;
            end
            REQ: begin
               if (gnt_i) begin
                  state_q <= BURST;
                  bcnt_q  <= '0;
               end
            end
            BURST: begin
               if (!gnt_i) begin
                  state_q <= REQ;
                  bcnt_q  <= '0;
                  gerr_q  <= 1'b1;
               end else if (bcnt_q == BLAST) begin
                  state_q <= GAP;
                  gcnt_q  <= '0;
                  done_q  <= 1'b1;
               end else begin
                  bcnt_q <= bcnt_q + 1'b1;
               end
            end
            GAP: begin
               if (gnt_i)
                  gerr_q <= 1'b1;
               if (gcnt_q == GLAST)
                  state_q <= (pend_q != '0) ? REQ : IDLE;
               else
                  gcnt_q <= gcnt_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_o     = (state_q == REQ) || (state_q == BURST);
   assign done_o    = done_q;
   assign gnt_err_o = gerr_q;
   assign ovf_o     = ovf_q;
   assign pend_o    = pend_q;

endmodule

module fsm_req_shaper #(
   parameter int BURST_LEN = 4,
   parameter int GAP_LEN   = 2,
   parameter int CNT_W     = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               job_0,
   input  logic               job_1,
   input  logic               job_2,
   input  logic               job_3,
   input  logic               gnt_0,
   input  logic               gnt_1,
   input  logic               gnt_2,
   input  logic               gnt_3,
   output logic               req_0,
   output logic               req_1,
   output logic               req_2,
   output logic               req_3,
   output logic [3:0]         done,
   output logic [4*CNT_W-1:0] pend_cnt,
   output logic [3:0]         overflow,
   output logic [3:0]         gnt_err
);

   logic [3:0] job_v;
   logic [3:0] gnt_v;
   logic [3:0] req_v;

   assign job_v = {job_3, job_2, job_1, job_0};
   assign gnt_v = {gnt_3, gnt_2, gnt_1, gnt_0};

   for (genvar n = 0; n < 4; n++) begin : g_ch
      fsm_req_shaper_chan #(
         .BURST_LEN(BURST_LEN),
         .GAP_LEN  (GAP_LEN),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clock    (clock),
         .reset    (reset),
         .job_i    (job_v[n]),
         .gnt_i    (gnt_v[n]),
         .req_o    (req_v[n]),
         .done_o   (done[n]),
         .gnt_err_o(gnt_err[n]),
         .ovf_o    (overflow[n]),
         .pend_o   (pend_cnt[n*CNT_W +: CNT_W])
      );
   end

   assign req_0 = req_v[0];
   assign req_1 = req_v[1];
   assign req_2 = req_v[2];
   assign req_3 = req_v[3];

endmodule

// File: tb/tb_fsm_req_shaper.sv
// Directed bench for fsm_req_shaper with the default parameters
// (BURST_LEN=4, GAP_LEN=2, CNT_W=3).

module tb_fsm_req_shaper;

   logic        clock;
   logic        reset;
   logic        job_0, job_1, job_2, job_3;
   logic        gnt_0, gnt_1, gnt_2, gnt_3;
   logic        req_0, req_1, req_2, req_3;
   logic [3:0]  done;
   logic [11:0] pend_cnt;
   logic [3:0]  overflow;
   logic [3:0]  gnt_err;

   int n_chk;
   int n_fail;

   typedef struct {
      logic       job;
      logic       gnt;
      logic       req;
      logic       dn;
      logic       gerr;
      logic [2:0] pend;
   } vec_t;

   vec_t tbl[11];

   fsm_req_shaper dut (
      .clock   (clock),
      .reset   (reset),
      .job_0   (job_0),
      .job_1   (job_1),
      .job_2   (job_2),
      .job_3   (job_3),
      .gnt_0   (gnt_0),
      .gnt_1   (gnt_1),
      .gnt_2   (gnt_2),
      .gnt_3   (gnt_3),
      .req_0   (req_0),
      .req_1   (req_1),
      .req_2   (req_2),
      .req_3   (req_3),
      .done    (done),
      .pend_cnt(pend_cnt),
      .overflow(overflow),
      .gnt_err (gnt_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [2:0] pend(input int n);
      return pend_cnt[n*3 +: 3];
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {job_0, job_1, job_2, job_3} = 4'b0;
      {gnt_0, gnt_1, gnt_2, gnt_3} = 4'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   int         highs[$];
   int         lows[$];
   logic [2:0] pd[$];
   int         hi_run;
   int         lo_run;
   logic       prev;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      // Single job on agent 0, grant = req delayed by one cycle
      // (including the trailing grant seen in the first gap cycle).
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

      do_reset();
      chk("rst_req", {28'd0, req_3, req_2, req_1, req_0}, 32'd0);
      chk("rst_pend", pend_cnt, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_ovf", overflow, 32'd0);

      // Async reset in the middle of a burst with two jobs pending
      job_0 = 1'b1;
      step();
      step();
      job_0 = 1'b0;
      gnt_0 = 1'b1;
      step();
      step();
      chk("midb_req", req_0, 32'd1);
      chk("midb_pend", pend(0), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("arst_req", req_0, 32'd0);
      chk("arst_pend", pend_cnt, 32'd0);
      chk("arst_done", done, 32'd0);
      chk("arst_ovf", overflow, 32'd0);
      chk("arst_gerr", gnt_err, 32'd0);

      do_reset();
      for (int i = 0; i < 11; i++) begin
         job_0 = tbl[i].job;
         gnt_0 = tbl[i].gnt;
         step();
         chk($sformatf("tbl%0d_req", i), req_0, tbl[i].req);
         chk($sformatf("tbl%0d_done", i), done[0], tbl[i].dn);
         chk($sformatf("tbl%0d_gerr", i), gnt_err[0], tbl[i].gerr);
         chk($sformatf("tbl%0d_pend", i), pend(0), tbl[i].pend);
      end
      gnt_0 = 1'b0;

      // Three back-to-back jobs on agent 1, zero-latency grant:
      // each high run is one REQ cycle plus a 4-cycle burst.
      do_reset();
      prev   = 1'b0;
      hi_run = 0;
      lo_run = 0;
      for (int c = 0; c < 40; c++) begin
         job_1 = (c < 3);
         gnt_1 = req_1;
         step();
         if (c == 2)
            chk("b2b_pend3", pend(1), 32'd3);
         if (done[1])
            pd.push_back(pend(1));
         if (req_1) begin
            if (!prev && highs.size() > 0)
               lows.push_back(lo_run);
            hi_run++;
            lo_run = 0;
         end else begin
            if (prev)
               highs.push_back(hi_run);
            hi_run = 0;
            lo_run++;
         end
         prev = req_1;
      end
      gnt_1 = 1'b0;
      chk("b2b_nbursts", highs.size(), 32'd3);
      foreach (highs[i])
         chk($sformatf("b2b_high%0d", i), highs[i], 32'd5);
      chk("b2b_ngaps", lows.size(), 32'd2);
      foreach (lows[i])
         chk($sformatf("b2b_gap%0d", i), lows[i], 32'd2);
      chk("b2b_ndone", pd.size(), 32'd3);
      foreach (pd[i])
         chk($sformatf("b2b_pend_at_done%0d", i), pd[i], 32'(2 - i));
      chk("b2b_end_req", req_1, 32'd0);
      chk("b2b_end_pend", pend(1), 32'd0);

      // Saturation on agent 2
      do_reset();
      for (int i = 0; i < 8; i++) begin
         job_2 = 1'b1;
         step();
         if (i == 6) begin
            chk("sat7_pend", pend(2), 32'd7);
            chk("sat7_ovf", overflow, 32'd0);
         end
      end
      job_2 = 1'b0;
      chk("sat8_pend", pend(2), 32'd7);
      chk("sat8_ovf", overflow, 32'b0100);
      chk("sat8_req", req_2, 32'd1);

      // Job on the completion edge while saturated: no overflow
      do_reset();
      job_2 = 1'b1;
      repeat (7) step();
      job_2 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         gnt_2 = 1'b1;
         job_2 = (k == 4);
         step();
      end
      job_2 = 1'b0;
      gnt_2 = 1'b0;
      chk("satc_done", done, 32'b0100);
      chk("satc_pend", pend(2), 32'd7);
      chk("satc_ovf", overflow, 32'd0);
      chk("satc_req", req_2, 32'd0);

      // Grant loss on agent 3 after two burst cycles
      do_reset();
      job_3 = 1'b1;
      step();
      job_3 = 1'b0;
      step();
      gnt_3 = 1'b1;
      step();
      step();
      gnt_3 = 1'b0;
      step();
      chk("gl_gerr", gnt_err, 32'b1000);
      chk("gl_req", req_3, 32'd1);
      chk("gl_pend", pend(3), 32'd1);
      step();
      chk("gl_gerr_clr", gnt_err, 32'd0);
      chk("gl_req_hold", req_3, 32'd1);
      gnt_3 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("gl_retry_req%0d", k), req_3, 32'(k < 4));
         chk($sformatf("gl_retry_done%0d", k), done[3], 32'(k == 4));
      end
      gnt_3 = 1'b0;
      chk("gl_end_pend", pend(3), 32'd0);

      // Spurious grant in IDLE, then simultaneous completions
      do_reset();
      gnt_1 = 1'b1;
      step();
      chk("sp_gerr", gnt_err, 32'b0010);
      chk("sp_req", req_1, 32'd0);
      gnt_1 = 1'b0;
      step();
      chk("sp_gerr_clr", gnt_err, 32'd0);
      job_0 = 1'b1;
      job_2 = 1'b1;
      step();
      job_0 = 1'b0;
      job_2 = 1'b0;
      step();
      gnt_0 = 1'b1;
      gnt_2 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 3)
            chk("sim_done_pre", done, 32'd0);
      end
      chk("sim_done", done, 32'b0101);
      chk("sim_gerr", gnt_err, 32'd0);
      gnt_0 = 1'b0;
      gnt_2 = 1'b0;
      step();
      chk("sim_done_clr", done, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fsm_req_shaper.md
Name: fsm_req_shaper

Overview:
- Upstream request conditioner for the 4-agent grant arbiter (req_0..req_3 in, gnt_0..gnt_3 out).
- Converts single-cycle job pulses from each agent into a per-agent pending-job count.
- Presents level requests to the arbiter and holds each request for a fixed burst once granted.
- Drops each request for a minimum gap after every burst, so the arbiter returns to idle and re-arbitrates.

Parameters:
- BURST_LEN, 4, granted cycles held per job (>=1)
- GAP_LEN, 2, cycles req_n is held low after each burst (>=1)
- CNT_W, 3, width of each per-agent pending counter

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- job_0..job_3  in  1 each  single-cycle job pulse from agent n
- gnt_0..gnt_3  in  1 each  grant from arbiter to agent n
- req_0..req_3  out  1 each  level request to arbiter for agent n
- done  out  4  bit n pulses 1 cycle when a burst for agent n completes
- pend_cnt  out  4*CNT_W  pending count of agent n in bits [n*CNT_W +: CNT_W]
- overflow  out  4  sticky; bit n set when job_n arrives with pend_n saturated
- gnt_err  out  4  bit n pulses 1 cycle on a lost or spurious grant for agent n

Behaviour:
- Four identical, independent agent channels. Each channel has a state register, bcnt (burst), gcnt (gap) and pend (CNT_W).
- Reset (async, any time, including mid-burst):
  - state=IDLE; pend, bcnt, gcnt = 0
  - req_n, done, gnt_err, overflow = 0, immediately
- req_n = 1 iff state is REQ or BURST. It is decoded from the state register only; there is no combinational path from job or gnt.
- Pending count:
  - On the edge where job_n=1: pend increments, saturating at 2^CNT_W-1. A job arriving while already saturated is dropped and sets overflow[n].
  - pend decrements at burst completion.
  - Job pulse on the same edge as completion: pend unchanged (or stays at max if saturated; no overflow in that case).
- States and transitions per channel:
  - IDLE: pend!=0 -> REQ. A job arriving in IDLE causes req_n high 2 cycles after the job edge (pend updates first, then state).
  - REQ: gnt_n=1 sampled -> BURST, bcnt=0. Otherwise stay.
  - BURST, gnt_n=1, bcnt==BURST_LEN-1 -> GAP, gcnt=0, done[n]=1 next cycle, pend decremented.
  - BURST, gnt_n=1, otherwise: bcnt+1.
  - BURST, gnt_n=0 (grant lost) -> REQ, bcnt=0, gnt_err[n] pulse, pend unchanged (the job is retried).
  - GAP: gcnt==GAP_LEN-1 -> REQ if pend!=0 (post-decrement value), else IDLE. Otherwise gcnt+1.
- Timing consequences:
  - req_n stays high for exactly BURST_LEN cycles after the first grant-sampling edge.
  - req_n is then low for GAP_LEN cycles minimum.
- Spurious grant: gnt_n=1 sampled in IDLE or GAP -> gnt_err[n] pulse, no state change.
- done and gnt_err are registered single-cycle pulses. overflow clears only on reset.
- Channels never interact. Simultaneous completions on several channels each assert their own done bit.

Test Plan:
- Reset: assert reset mid-BURST on agent 0 (pend_0=2) -> req_0=0 asynchronously; pend_cnt=0, done=0, overflow=0 before the next edge.
- Single job: job_0 pulse at edge t, gnt_0 mirrors req_0 with 1-cycle latency.
  - req_0 rises after edge t+1 and stays high 4 cycles after the first gnt_0 sample.
  - done[0] pulses once; req_0 then low for 2 cycles; pend_0 goes 1->0 and the channel ends in IDLE.
- Back-to-back jobs: 3 job_1 pulses, then grants always given.
  - Three bursts of 4, separated by exactly 2 low cycles.
  - done[1] pulses 3 times; pend_1 goes 3,2,1,0.
- Saturation: 8 job_2 pulses with no grant (CNT_W=3) -> pend_2=7 and overflow[2]=1 from the 8th pulse.
  - A job_2 on the completion edge keeps pend_2=7 with no new overflow event.
- Grant loss: drop gnt_3 after 2 burst cycles.
  - gnt_err[3] pulses; req_3 stays high (REQ); pend_3 unchanged.
  - The next grant restarts a full 4-cycle burst.
- Spurious grant plus independence: gnt_1=1 while agent 1 is IDLE -> gnt_err[1] pulse, req_1 stays 0.
  - Agents 0 and 2 finishing bursts on the same edge -> done=4'b0101.
